// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the PC redirect controller.
package cpu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [1:0] PRI_JUMP   = 2'd0;
  localparam logic [1:0] PRI_BRANCH = 2'd1;
  localparam logic [1:0] PRI_MISP   = 2'd2;
  localparam logic [1:0] PRI_TRAP   = 2'd3;
  typedef enum logic [1:0] {RUN, HOLD_REDIR, FENCE_WAIT, FENCE_REFILL} state_e;
endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational fixed-priority picker over the redirect sources.
module pc_redirect_arb import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            mispredict_valid_i,
  input  logic [XLEN-1:0] mispredict_pc_i,
  input  logic            branch_valid_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_valid_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            valid_o,
  output logic [XLEN-1:0] target_o,
  output logic [1:0]      pri_o,
  output logic            flush_id_o
);
  assign valid_o    = trap_valid_i | mispredict_valid_i | branch_valid_i | jump_valid_i;
  assign pri_o      = trap_valid_i ? PRI_TRAP : mispredict_valid_i ? PRI_MISP :
                      branch_valid_i ? PRI_BRANCH : PRI_JUMP;
  assign target_o   = trap_valid_i ? trap_addr_i : mispredict_valid_i ? mispredict_pc_i + XLEN'(4) :
                      branch_valid_i ? branch_target_i : jump_target_i;
  // a decode-stage jump leaves the jump itself in ID, so only IF is squashed
  assign flush_id_o = pri_o != PRI_JUMP;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences PC redirects, buffers them across MMU stalls and runs fence drain/refill.
module pc_redirect_ctrl import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            mispredict_valid_i,
  input  logic [XLEN-1:0] mispredict_pc_i,
  input  logic            branch_valid_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_valid_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            fence_valid_i,
  input  logic [XLEN-1:0] fence_pc_i,
  input  logic            drain_empty_i,
  input  logic            stall_mmu_i,
  input  logic            stall_early_i,
  output logic            pc_load_o,
  output logic [XLEN-1:0] pc_addr_o,
  output logic            pc_hold_o,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            fence_busy_o
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d, fence_pc_q, fence_pc_d, arb_target, req_addr, addr_d;
  logic [1:0] pend_pri_q, pend_pri_d, arb_pri, req_pri;
  logic pend_fid_q, pend_fid_d, arb_valid, arb_fid, req_fid, use_pend, urgent, take;
  logic load_d, hold_d, fif_d, fid_d, busy_d;
  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .trap_valid_i       (trap_valid_i),
    .trap_addr_i        (trap_addr_i),
    .mispredict_valid_i (mispredict_valid_i),
    .mispredict_pc_i    (mispredict_pc_i),
    .branch_valid_i     (branch_valid_i),
    .branch_target_i    (branch_target_i),
    .jump_valid_i       (jump_valid_i),
    .jump_target_i      (jump_target_i),
    .valid_o            (arb_valid),
    .target_o           (arb_target),
    .pri_o              (arb_pri),
    .flush_id_o         (arb_fid)
  );
  // while holding, a new request replaces the pending one only at equal or higher priority
  assign use_pend = state_q == HOLD_REDIR && !(arb_valid && arb_pri >= pend_pri_q);
  assign req_addr = use_pend ? pend_addr_q : arb_target;
  assign req_pri  = use_pend ? pend_pri_q : arb_pri;
  assign req_fid  = use_pend ? pend_fid_q : arb_fid;
  assign urgent   = arb_valid && arb_pri >= PRI_MISP;
  always_comb begin
    state_d    = state_q;
    pend_addr_d = pend_addr_q;
    pend_pri_d = pend_pri_q;
    pend_fid_d = pend_fid_q;
    fence_pc_d = fence_pc_q;
    addr_d     = pc_addr_o;
    load_d     = 1'b0;
    hold_d     = 1'b0;
    fif_d      = 1'b0;
    fid_d      = 1'b0;
    busy_d     = 1'b0;
    take       = 1'b0;
    case (state_q)
      RUN: begin
        take = arb_valid;
        if (!arb_valid && fence_valid_i) begin
          state_d    = FENCE_WAIT;
          fence_pc_d = fence_pc_i;
          hold_d     = 1'b1;
          busy_d     = 1'b1;
        end else if (!arb_valid) hold_d = stall_early_i | stall_mmu_i;
      end
      HOLD_REDIR: take = 1'b1;
      FENCE_WAIT: begin
        take = urgent;
        if (!urgent) begin
          state_d = drain_empty_i ? FENCE_REFILL : FENCE_WAIT;
          load_d  = drain_empty_i;
          addr_d  = drain_empty_i ? fence_pc_q + XLEN'(4) : pc_addr_o;
          fif_d   = drain_empty_i;
          hold_d  = !drain_empty_i;
          busy_d  = 1'b1;
        end
      end
      FENCE_REFILL: begin
        take = urgent;
        if (!urgent) begin
          state_d = RUN;
          hold_d  = stall_early_i | stall_mmu_i;
        end
      end
    endcase
    if (take) begin
      if (stall_mmu_i) begin
        state_d     = HOLD_REDIR;
        pend_addr_d = req_addr;
        pend_pri_d  = req_pri;
        pend_fid_d  = req_fid;
        hold_d      = 1'b1;
      end else begin
        state_d = RUN;
        load_d  = 1'b1;
        addr_d  = req_addr;
        fif_d   = 1'b1;
        fid_d   = req_fid;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      pend_addr_q  <= '0;
      pend_pri_q   <= '0;
      pend_fid_q   <= 1'b0;
      fence_pc_q   <= '0;
      pc_load_o    <= 1'b0;
      pc_addr_o    <= '0;
      pc_hold_o    <= 1'b0;
      flush_if_o   <= 1'b0;
      flush_id_o   <= 1'b0;
      fence_busy_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      pend_pri_q   <= pend_pri_d;
      pend_fid_q   <= pend_fid_d;
      fence_pc_q   <= fence_pc_d;
      pc_load_o    <= load_d;
      pc_addr_o    <= addr_d;
      pc_hold_o    <= hold_d;
      flush_if_o   <= fif_d;
      flush_id_o   <= fid_d;
      fence_busy_o <= busy_d;
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vectors with hand-computed expectations for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic trap_valid, mispredict_valid, branch_valid, jump_valid, fence_valid;
  logic [31:0] trap_addr, mispredict_pc, branch_target, jump_target, fence_pc, pc_addr;
  logic drain_empty, stall_mmu, stall_early;
  logic pc_load, pc_hold, flush_if, flush_id, fence_busy;
  logic [4:0] outs;
  int n_chk = 0, n_fail = 0;
  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid), .trap_addr_i(trap_addr),
    .mispredict_valid_i(mispredict_valid), .mispredict_pc_i(mispredict_pc),
    .branch_valid_i(branch_valid), .branch_target_i(branch_target),
    .jump_valid_i(jump_valid), .jump_target_i(jump_target),
    .fence_valid_i(fence_valid), .fence_pc_i(fence_pc),
    .drain_empty_i(drain_empty), .stall_mmu_i(stall_mmu), .stall_early_i(stall_early),
    .pc_load_o(pc_load), .pc_addr_o(pc_addr), .pc_hold_o(pc_hold),
    .flush_if_o(flush_if), .flush_id_o(flush_id), .fence_busy_o(fence_busy)
  );
  always #5 clk = ~clk;
  // {load, hold, flush_if, flush_id, fence_busy}
  assign outs = {pc_load, pc_hold, flush_if, flush_id, fence_busy};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic idle();
    trap_valid = 0; mispredict_valid = 0; branch_valid = 0; jump_valid = 0; fence_valid = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    trap_addr = 0; mispredict_pc = 0; branch_target = 0; jump_target = 0; fence_pc = 0;
    drain_empty = 0; stall_mmu = 0; stall_early = 0;
    #2;
    chk("reset_outs", 32'(outs), 32'h0);
    chk("reset_addr", pc_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step();
    chk("idle_outs", 32'(outs), 32'h0);
    branch_valid = 1; branch_target = 32'h100;
    step(); idle();
    chk("branch_outs", 32'(outs), 32'b10110);
    chk("branch_addr", pc_addr, 32'h100);
    step();
    chk("branch_pulse_end", 32'(outs), 32'h0);
    trap_valid = 1; trap_addr = 32'h8000_0000; mispredict_valid = 1; mispredict_pc = 32'h40;
    step(); idle();
    chk("trap_wins_outs", 32'(outs), 32'b10110);
    chk("trap_wins_addr", pc_addr, 32'h8000_0000);
    mispredict_valid = 1; mispredict_pc = 32'hFFFF_FFFC;
    step(); idle();
    chk("misp_wrap_outs", 32'(outs), 32'b10110);
    chk("misp_wrap_addr", pc_addr, 32'h0);
    jump_valid = 1; jump_target = 32'h50;
    step(); idle();
    chk("jump_outs", 32'(outs), 32'b10100);
    chk("jump_addr", pc_addr, 32'h50);
    stall_mmu = 1; jump_valid = 1; jump_target = 32'h20;
    step(); idle();
    chk("hold_c1", 32'(outs), 32'b01000);
    branch_valid = 1; branch_target = 32'h30;
    step(); idle();
    chk("hold_c2", 32'(outs), 32'b01000);
    jump_valid = 1; jump_target = 32'h99;
    step(); idle();
    chk("hold_c3_drop_low", 32'(outs), 32'b01000);
    stall_mmu = 0;
    step();
    chk("hold_release_outs", 32'(outs), 32'b10110);
    chk("hold_release_addr", pc_addr, 32'h30);
    step();
    chk("hold_release_end", 32'(outs), 32'h0);
    stall_mmu = 1; jump_valid = 1; jump_target = 32'h60;
    step(); idle();
    chk("hold2_enter", 32'(outs), 32'b01000);
    stall_mmu = 0; trap_valid = 1; trap_addr = 32'h70;
    step(); idle();
    chk("hold2_new_wins_outs", 32'(outs), 32'b10110);
    chk("hold2_new_wins_addr", pc_addr, 32'h70);
    stall_early = 1;
    step();
    chk("stall_early_hold", 32'(outs), 32'b01000);
    branch_valid = 1; branch_target = 32'h500;
    step(); idle(); stall_early = 0;
    chk("stall_early_redirect", 32'(outs), 32'b10110);
    chk("stall_early_addr", pc_addr, 32'h500);
    fence_valid = 1; fence_pc = 32'h200;
    step(); idle();
    chk("fence_wait0", 32'(outs), 32'b01001);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("fence_wait%0d", i), 32'(outs), 32'b01001);
    end
    drain_empty = 1;
    step(); drain_empty = 0;
    chk("fence_refill_outs", 32'(outs), 32'b10101);
    chk("fence_refill_addr", pc_addr, 32'h204);
    step();
    chk("fence_done", 32'(outs), 32'h0);
    fence_valid = 1; fence_pc = 32'h200;
    step(); idle();
    chk("abort_wait", 32'(outs), 32'b01001);
    trap_valid = 1; trap_addr = 32'h10;
    step(); idle(); drain_empty = 1;
    chk("abort_trap_outs", 32'(outs), 32'b10110);
    chk("abort_trap_addr", pc_addr, 32'h10);
    step();
    chk("abort_no_refill", 32'(outs), 32'h0);
    step(); drain_empty = 0;
    chk("abort_no_refill2", 32'(outs), 32'h0);
    trap_valid = 1; trap_addr = 32'h300; fence_valid = 1; fence_pc = 32'h400;
    step(); idle(); drain_empty = 1;
    chk("trap_vs_fence_outs", 32'(outs), 32'b10110);
    chk("trap_vs_fence_addr", pc_addr, 32'h300);
    step(); drain_empty = 0;
    chk("trap_vs_fence_nofence", 32'(outs), 32'h0);
    stall_mmu = 1; branch_valid = 1; branch_target = 32'h700;
    step(); idle();
    chk("rst_hold_enter", 32'(outs), 32'b01000);
    #2 rst = 1;
    #1;
    chk("rst_async_outs", 32'(outs), 32'h0);
    chk("rst_async_addr", pc_addr, 32'h0);
    stall_mmu = 0;
    step();
    rst = 0;
    step();
    chk("rst_no_pending", 32'(outs), 32'h0);
    step();
    chk("rst_no_pending2", 32'(outs), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-redirect controller that sequences every non-sequential update of the program counter. It arbitrates trap, mispredict-recovery, resolved-branch and early-jump redirect requests by priority, buffers a redirect that arrives while fetch is frozen by an MMU stall, and runs the fence drain/refill sequence. It sits between the hazard/branch/CSR logic and the PC register, driving the PC's load/hold controls and the IF/ID flush lines.

## Interface
- XLEN, 32, address width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- trap_valid / trap_addr  in  1 / XLEN  CSR trap or return redirect, target used as-is
- mispredict_valid / mispredict_pc  in  1 / XLEN  wrong-path recovery, target = mispredict_pc + 4
- branch_valid / branch_target  in  1 / XLEN  EX-resolved branch/jump target
- jump_valid / jump_target  in  1 / XLEN  early (decode) jump target
- fence_valid / fence_pc  in  1 / XLEN  fence in decode, PC of the fence
- drain_empty  in  1  store buffer and memory pipe idle
- stall_mmu  in  1  fetch frozen by MMU. PC must not change.
- stall_early  in  1  decode-side hazard stall
- pc_load  out  1  load pc_addr into PC this cycle
- pc_addr  out  XLEN  redirect target
- pc_hold  out  1  PC keeps its value this cycle
- flush_if / flush_id  out  1  squash the IF / ID pipeline register
- fence_busy  out  1  fence sequence in progress

## Operation
- Priority, highest first: trap (3), mispredict (2), branch (1), jump (0). A combinational arbiter picks the winner each cycle.
- States: RUN, HOLD_REDIR, FENCE_WAIT, FENCE_REFILL. Reset state is RUN.
- RUN, winner present, stall_mmu=0:
  - Next cycle: pc_load=1 and pc_addr=target.
  - flush_if=1 for all sources. flush_id=1 for trap, mispredict and branch, but not for jump.
- RUN, winner present, stall_mmu=1: latch the target and its priority into the pending register, then go to HOLD_REDIR.
- HOLD_REDIR:
  - pc_hold=1.
  - A new request with priority >= pending overwrites the pending register. A lower-priority request is dropped.
  - When stall_mmu is sampled 0, issue the pending load the next cycle, with flushes per the source of the pending entry, and return to RUN.
- RUN, fence_valid=1, no winner: capture fence_pc and go to FENCE_WAIT. Go there even if stall_mmu=1.
- FENCE_WAIT:
  - pc_hold=1 and fence_busy=1.
  - When drain_empty is sampled 1, go to FENCE_REFILL.
- FENCE_REFILL: pc_load=1, pc_addr=fence_pc+4, flush_if=1, fence_busy=1, then go to RUN. This refetches everything after the fence.
- A trap or mispredict in FENCE_WAIT or FENCE_REFILL aborts the fence and is handled as in RUN. Branch and jump requests are ignored there.
- stall_early alone does not block redirects, because a redirect overrides the stall. In RUN with no redirect, pc_hold = stall_early | stall_mmu.
- Adders are XLEN-bit and wrap modulo 2^XLEN, so 0xFFFF_FFFC+4 = 0.
- pc_load and pc_hold are never both 1 in the same cycle. pc_load wins.

## Timing
- Registered outputs. Latency from request sampled at edge N to pc_load high in cycle N+1 is 1 cycle.
- pc_load, flush_if and flush_id are single-cycle pulses for each redirect.
- Reset: all outputs are 0, pc_addr=0, pending register cleared, state RUN. Reset asserted mid-sequence discards the pending redirect or fence immediately, with no load issued.
- Simultaneous trap and fence_valid: the trap wins and the fence is not entered.
- Simultaneous stall_mmu falling and a new higher-priority request in HOLD_REDIR: the new request is issued.
- Fence latency is at least 2 cycles, plus the wait for drain_empty.

## Structure
- cpu_pkg holds the state enum, the 2-bit redirect-priority codes (PRI_JUMP..PRI_TRAP) and the XLEN default.
- One sub-module, pc_redirect_arb, is the combinational priority picker. It outputs valid, target (with the +4 applied for mispredict), priority and a flush_id flag.
- FSM, pending register and output registers live in pc_redirect_ctrl.

## Test plan
- branch_valid, branch_target=0x100 -> next cycle: pc_load=1, pc_addr=0x100, flush_if=1, flush_id=1. The cycle after, all pulses are 0.
- Same cycle: trap_addr=0x8000_0000 with mispredict_pc=0x40 -> pc_addr=0x8000_0000. Then mispredict alone with mispredict_pc=0xFFFF_FFFC -> pc_addr=0x0.
- stall_mmu=1 for 3 cycles; jump_target=0x20 arrives in cycle 1, branch_target=0x30 in cycle 2 -> pc_hold=1 throughout. pc_load with 0x30 comes one cycle after stall_mmu falls.
- fence_valid with fence_pc=0x200, drain_empty low for 4 cycles -> fence_busy=1 and pc_hold=1 while waiting. Then pc_load with 0x204 and flush_if=1, and fence_busy drops the following cycle.
- FENCE_WAIT, then trap_valid with trap_addr=0x10 -> pc_load with 0x10 next cycle, fence aborted, no 0x204 load afterwards.
- rst asserted while in HOLD_REDIR -> outputs go to 0 asynchronously. After release, no pending load is issued.
